// File: rtl/dfi_pkg.sv
// Shared DFI read-path definitions: default phase count, config field widths
// and phase bookkeeping helpers used by the aligner and its delay lines.
package dfi_pkg;
  localparam int DFI_NPHASES = 8;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int lat_w(input int max_lat);
    return clog2_min1(max_lat + 1);
  endfunction

  function automatic int slip_w(input int nphases);
    return clog2_min1(nphases);
  endfunction

  // Element index in a {current cycle, history} window of phases, where the
  // window holds hist_phases older phases below the current cycle.
  function automatic int phase_idx(input int hist_phases, input int p, input int dly);
    return hist_phases + p - dly;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/dfi_phase_delay.sv
// Phase-granular delay line: output phase p of this cycle is the input from
// dly phases earlier in the flattened phase stream (combinational select).
module dfi_phase_delay
  import dfi_pkg::*;
#(
  parameter int NPHASES = DFI_NPHASES,
  parameter int W = 1,
  parameter int MAX_DLY = 0,
  localparam int DLY_W = clog2_min1(MAX_DLY + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NPHASES*W-1:0] din,
  input  logic [DLY_W-1:0]     dly,
  output logic [NPHASES*W-1:0] dout
);
  localparam int HIST_RAW = (MAX_DLY + NPHASES - 1) / NPHASES;
  localparam int HIST_CYC = (HIST_RAW < 1) ? 1 : HIST_RAW;
  localparam int HP = HIST_CYC * NPHASES;

  // Newest cycle sits at the top so {din, hist} is one contiguous phase stream.
  logic [HP*W-1:0]           hist;
  logic [(HP+NPHASES)*W-1:0] win;

  assign win = {din, hist};

  if (HIST_CYC == 1) begin : g_one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     hist <= '0;
      else if (flush) hist <= '0;
      else            hist <= din;
    end
  end else begin : g_shift
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     hist <= '0;
      else if (flush) hist <= '0;
      else            hist <= {din, hist[HP*W-1 -: (HP-NPHASES)*W]};
    end
  end

  always_comb begin
    dout = '0;
    for (int p = 0; p < NPHASES; p++) begin
      for (int d = 0; d <= MAX_DLY; d++) begin
        if (dly == DLY_W'(d)) dout[p*W +: W] = win[phase_idx(HP, p, d)*W +: W];
      end
    end
  end
endmodule

// File: rtl/dfi_rddata_aligner.sv
// DFI read-path aligner: delays per-phase read enables by a trained latency,
// slips raw PHY data by a trained phase offset, and tracks beats for training.
module dfi_rddata_aligner
  import dfi_pkg::*;
#(
  parameter int NPHASES = DFI_NPHASES,
  parameter int DW = 32,
  parameter int MAX_LAT = 63,
  parameter int CNT_W = 16,
  localparam int LAT_W = lat_w(MAX_LAT),
  localparam int SLIP_W = slip_w(NPHASES),
  localparam int IF_W = $clog2(NPHASES + MAX_LAT + 1) + 1
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic [NPHASES-1:0]    dfi_rddata_en,
  input  logic [NPHASES*DW-1:0] phy_rddata,
  output logic [NPHASES*DW-1:0] dfi_rddata,
  output logic [NPHASES-1:0]    dfi_rddata_valid,
  input  logic [LAT_W-1:0]      cfg_rdlat,
  input  logic [SLIP_W-1:0]     cfg_rdslip,
  output logic                  cfg_busy,
  output logic [CNT_W-1:0]      beat_cnt,
  input  logic                  beat_clr
);
  logic [LAT_W-1:0]      lat_q, req_lat;
  logic [SLIP_W-1:0]     slip_q, req_slip;
  logic [IF_W-1:0]       inflight_q, inflight_d;
  logic [NPHASES-1:0]    vld_d;
  logic [NPHASES*DW-1:0] dat_d;
  logic                  cfg_diff, cfg_load, busy_d;
  logic [CNT_W:0]        cnt_sum;
  logic [CNT_W-1:0]      cnt_d;

  assign req_lat  = (cfg_rdlat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : cfg_rdlat;
  assign req_slip = (NPHASES == 1) ? '0 : cfg_rdslip;
  assign cfg_diff = (req_lat != lat_q) || (req_slip != slip_q);

  // Switch only when nothing is pending, so no beat is ever re-timed mid-flight.
  assign cfg_load = cfg_diff && (inflight_q == '0) && (dfi_rddata_en == '0);

  // Emitted enables still sit in the history; flushing on a latency change
  // keeps a longer new latency from replaying them.
  dfi_phase_delay #(.NPHASES(NPHASES), .W(1), .MAX_DLY(MAX_LAT)) u_en_dly (
    .clk   (clk_sys),
    .rst_n (rst_sys_n),
    .flush (cfg_load),
    .din   (dfi_rddata_en),
    .dly   (lat_q),
    .dout  (vld_d)
  );

  dfi_phase_delay #(.NPHASES(NPHASES), .W(DW), .MAX_DLY(NPHASES - 1)) u_dat_dly (
    .clk   (clk_sys),
    .rst_n (rst_sys_n),
    .flush (1'b0),
    .din   (phy_rddata),
    .dly   (slip_q),
    .dout  (dat_d)
  );

  assign inflight_d = inflight_q + IF_W'(popcount(16'(dfi_rddata_en)))
                    - IF_W'(popcount(16'(vld_d)));
  assign busy_d     = (cfg_load ? 1'b0 : cfg_diff) || (inflight_d != '0);

  assign cnt_sum = (beat_clr ? '0 : {1'b0, beat_cnt}) + (CNT_W+1)'(popcount(16'(vld_d)));
  assign cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      dfi_rddata       <= '0;
      dfi_rddata_valid <= '0;
      inflight_q       <= '0;
      beat_cnt         <= '0;
      cfg_busy         <= 1'b0;
      lat_q            <= '0;
      slip_q           <= '0;
    end else begin
      dfi_rddata       <= dat_d;
      dfi_rddata_valid <= vld_d;
      inflight_q       <= inflight_d;
      beat_cnt         <= cnt_d;
      cfg_busy         <= busy_d;
      if (cfg_load) begin
        lat_q  <= req_lat;
        slip_q <= req_slip;
      end
    end
  end
endmodule

// File: tb/tb_dfi_rddata_aligner.sv
// Bench for dfi_rddata_aligner: directed vector table, hand sequences for
// config handoff, slip and reset, then random traffic against a phase model.
module tb_dfi_rddata_aligner;
  localparam int NP      = 8;
  localparam int DW      = 32;
  localparam int MAX_LAT = 63;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int CW      = NP * DW;

  logic             clk_sys = 1'b0;
  logic             rst_sys_n = 1'b0;
  logic [NP-1:0]    dfi_rddata_en = '0;
  logic [CW-1:0]    phy_rddata = '0;
  logic [CW-1:0]    dfi_rddata;
  logic [NP-1:0]    dfi_rddata_valid;
  logic [5:0]       cfg_rdlat = '0;
  logic [2:0]       cfg_rdslip = '0;
  logic             cfg_busy;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat_clr = 1'b0;

  always #5 clk_sys = ~clk_sys;

  dfi_rddata_aligner #(.NPHASES(NP), .DW(DW), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
    .clk_sys          (clk_sys),
    .rst_sys_n        (rst_sys_n),
    .dfi_rddata_en    (dfi_rddata_en),
    .phy_rddata       (phy_rddata),
    .dfi_rddata       (dfi_rddata),
    .dfi_rddata_valid (dfi_rddata_valid),
    .cfg_rdlat        (cfg_rdlat),
    .cfg_rdslip       (cfg_rdslip),
    .cfg_busy         (cfg_busy),
    .beat_cnt         (beat_cnt),
    .beat_clr         (beat_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: every enable is scheduled for emission at its global
  // phase + NP + active latency; data is looked up by global phase index.
  int            cyc;
  int            m_lat, m_slip, m_cnt;
  int            sched_q[$];
  logic [DW-1:0] r_mem[int];
  logic [NP-1:0] exp_v;
  logic [CW-1:0] exp_d;
  logic          exp_busy;

  typedef struct {
    logic [NP-1:0] en;
    int            lat;
    logic          clr;
    logic [NP-1:0] exp_valid;
    int            exp_cnt;
    logic          exp_busy;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [CW-1:0] rand_data();
    logic [CW-1:0] d;
    for (int p = 0; p < NP; p++) d[p*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    cyc = 0;
    sched_q.delete();
    r_mem.delete();
    m_lat = 0;
    m_slip = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic [NP-1:0] en, input logic [CW-1:0] data,
                            input int lat, input int slip, input logic clr);
    int base, inflight, pend, idx, req_lat;
    int keep_q[$];
    base = NP * cyc;
    req_lat = (lat > MAX_LAT) ? MAX_LAT : lat;
    foreach (sched_q[i]) if (sched_q[i] >= base + NP) keep_q.push_back(sched_q[i]);
    sched_q = keep_q;
    inflight = sched_q.size();
    for (int p = 0; p < NP; p++) r_mem[base + p] = data[p*DW +: DW];
    for (int p = 0; p < NP; p++) if (en[p]) sched_q.push_back(base + p + NP + m_lat);
    exp_v = '0;
    foreach (sched_q[i]) if (sched_q[i] < base + 2*NP) exp_v[sched_q[i] - base - NP] = 1'b1;
    for (int p = 0; p < NP; p++) begin
      idx = base + p - m_slip;
      exp_d[p*DW +: DW] = r_mem.exists(idx) ? r_mem[idx] : '0;
    end
    if ((req_lat != m_lat || slip != m_slip) && inflight == 0 && en == '0) begin
      m_lat = req_lat;
      m_slip = slip;
    end
    m_cnt = (clr ? 0 : m_cnt) + $countones(exp_v);
    if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
    pend = 0;
    foreach (sched_q[i]) if (sched_q[i] >= base + 2*NP) pend++;
    exp_busy = (req_lat != m_lat) || (slip != m_slip) || (pend != 0);
    cyc++;
  endtask

  // Entered and left at a falling edge: drive, advance one clock, compare.
  task automatic step(input logic [NP-1:0] en, input logic [CW-1:0] data,
                      input int lat, input int slip, input logic clr);
    dfi_rddata_en = en;
    phy_rddata    = data;
    cfg_rdlat     = 6'(lat);
    cfg_rdslip    = 3'(slip);
    beat_clr      = clr;
    model_step(en, data, lat, slip, clr);
    @(posedge clk_sys);
    #1;
    check("valid", CW'(dfi_rddata_valid), CW'(exp_v));
    check("rddata", dfi_rddata, exp_d);
    check("beat_cnt", CW'(beat_cnt), CW'(m_cnt));
    check("cfg_busy", CW'(cfg_busy), CW'(exp_busy));
    @(negedge clk_sys);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, CW'(dfi_rddata_valid), '0);
    check({tag, "_rddata"}, dfi_rddata, '0);
    check({tag, "_beat_cnt"}, CW'(beat_cnt), '0);
    check({tag, "_busy"}, CW'(cfg_busy), '0);
  endtask

  task automatic do_reset(input int hold);
    rst_sys_n     = 1'b0;
    dfi_rddata_en = '0;
    phy_rddata    = '0;
    beat_clr      = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (hold) @(negedge clk_sys);
    check_zero("rst_hold");
    rst_sys_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [CW-1:0] ramp, slip_exp;
    int cur_lat, cur_slip;

    tbl[0]  = '{8'h01,  0, 1'b0, 8'h01,  1, 1'b0};
    tbl[1]  = '{8'h00,  0, 1'b0, 8'h00,  1, 1'b0};
    tbl[2]  = '{8'h00, 11, 1'b0, 8'h00,  1, 1'b0};
    tbl[3]  = '{8'h80, 11, 1'b0, 8'h00,  1, 1'b1};
    tbl[4]  = '{8'h00, 11, 1'b0, 8'h00,  1, 1'b1};
    tbl[5]  = '{8'h00, 11, 1'b0, 8'h04,  2, 1'b0};
    tbl[6]  = '{8'hFF, 11, 1'b0, 8'h00,  2, 1'b1};
    tbl[7]  = '{8'hFF, 11, 1'b0, 8'hF8,  7, 1'b1};
    tbl[8]  = '{8'h00, 11, 1'b1, 8'hFF,  8, 1'b1};
    tbl[9]  = '{8'h00, 11, 1'b0, 8'h07, 11, 1'b0};
    tbl[10] = '{8'hFF, 11, 1'b0, 8'h00, 11, 1'b1};
    tbl[11] = '{8'hFF, 11, 1'b0, 8'hF8, 15, 1'b1};
    tbl[12] = '{8'hFF, 11, 1'b0, 8'hFF, 15, 1'b1};
    tbl[13] = '{8'h00, 11, 1'b0, 8'hFF, 15, 1'b1};
    tbl[14] = '{8'h00, 11, 1'b0, 8'h07, 15, 1'b0};
    tbl[15] = '{8'h00,  4, 1'b0, 8'h00, 15, 1'b0};
    tbl[16] = '{8'hFF,  4, 1'b0, 8'hF0, 15, 1'b1};
    tbl[17] = '{8'h00,  4, 1'b1, 8'h0F,  4, 1'b0};

    model_reset();
    #2;
    check_zero("reset");
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;

    repeat (5) step('0, rand_data(), 0, 0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, rand_data(), tbl[i].lat, 0, tbl[i].clr);
      check($sformatf("tbl%0d_valid", i), CW'(dfi_rddata_valid), CW'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_cnt", i), CW'(beat_cnt), CW'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_busy", i), CW'(cfg_busy), CW'(tbl[i].exp_busy));
    end

    // Latency change with four beats outstanding keeps the old latency.
    step(8'hFF, rand_data(), 4, 0, 1'b0);
    step(8'h00, rand_data(), 20, 0, 1'b0);
    check("lat_pending_busy", CW'(cfg_busy), CW'(1'b1));
    check("lat_pending_valid", CW'(dfi_rddata_valid), CW'(8'h0F));
    step(8'h00, rand_data(), 20, 0, 1'b0);
    check("lat_loaded_busy", CW'(cfg_busy), CW'(1'b0));
    step(8'h80, rand_data(), 20, 0, 1'b0);
    repeat (5) step('0, rand_data(), 20, 0, 1'b0);

    // Slip of 3: phases 5..7 come from the previous cycle.
    for (int p = 0; p < NP; p++) begin
      ramp[p*DW +: DW]     = DW'(p);
      slip_exp[p*DW +: DW] = DW'((p + 5) % NP);
    end
    step('0, ramp, 20, 3, 1'b0);
    step('0, ramp, 20, 3, 1'b0);
    check("slip3_data", dfi_rddata, slip_exp);

    // Reset in the middle of a burst at a long latency.
    step('0, rand_data(), 40, 0, 1'b0);
    step(8'hFF, rand_data(), 40, 0, 1'b0);
    step(8'hFF, rand_data(), 40, 0, 1'b0);
    step(8'h03, rand_data(), 40, 0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      step('0, rand_data(), 40, 0, 1'b0);
      check("post_rst_valid", CW'(dfi_rddata_valid), '0);
    end

    cur_lat  = 40;
    cur_slip = 0;
    for (int i = 0; i < 400; i++) begin
      logic [NP-1:0] en;
      if ($urandom_range(0, 24) == 0) begin
        cur_lat  = $urandom_range(0, MAX_LAT);
        cur_slip = $urandom_range(0, NP - 1);
      end
      case ($urandom_range(0, 3))
        0, 1:    en = '0;
        2:       en = NP'($urandom);
        default: en = '1;
      endcase
      step(en, rand_data(), cur_lat, cur_slip, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
